// File: rtl/gate_pkg.sv
// Shared gate-function encoding and evaluator for the gate logic unit and its bench model.
package gate_pkg;

  localparam int GLU_MAX_W = 64;

  typedef enum logic [2:0] {
    OP_BUF  = 3'd0,
    OP_NOT  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  // Evaluated at full width; callers truncate to their own operand width.
  function automatic logic [GLU_MAX_W-1:0] glu_eval(input op_e op,
                                                     input logic [GLU_MAX_W-1:0] a,
                                                     input logic [GLU_MAX_W-1:0] b);
    logic [GLU_MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_BUF:  r = a;
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_skid_buffer.sv
// Two-entry valid/ready register slice: an output stage plus one skid entry.
// in_ready is a flop (the inverse of skid occupancy), so it never sees out_ready combinationally.
module gate_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         load_out;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign load_out = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (load_out) begin
      // Skid entry is older than anything at the input, so it drains first.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/gate_logic_unit.sv
// Registered WIDTH-bit bitwise gate unit (BUF/NOT/AND/OR/XOR/NAND/NOR/XNOR) with skid output.
// Define GLU_STATS_EN to add the txn_count port counting completed output transfers.
module gate_logic_unit
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef GLU_STATS_EN
  ,
  output logic [CNT_W-1:0] txn_count
`endif
);

  if (WIDTH < 1 || WIDTH > GLU_MAX_W || CNT_W < 1) begin : g_bad_param
    $error("gate_logic_unit: WIDTH must be 1..64 and CNT_W at least 1");
  end

  logic [WIDTH-1:0] result;

  assign result = WIDTH'(glu_eval(op, GLU_MAX_W'(a), GLU_MAX_W'(b)));

  gate_skid_buffer #(
    .W(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (y)
  );

`ifdef GLU_STATS_EN
  // Free-running; wraps to zero after all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count <= '0;
    end else if (out_valid && out_ready) begin
      txn_count <= txn_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_logic_unit.sv
// Directed-vector bench for gate_logic_unit (WIDTH=8); stats checks run when GLU_STATS_EN is defined.
module tb_gate_logic_unit;
  import gate_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  op_e        op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
`ifdef GLU_STATS_EN
  logic [3:0] txn_count;
`endif

  int vectors;
  int miscompares;
  int results;

  logic [7:0] sweep_exp [8];

  gate_logic_unit #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
`ifdef GLU_STATS_EN
    ,
    .txn_count(txn_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    results     = 0;
    sweep_exp   = '{8'hA5, 8'h5A, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = OP_BUF;
    a         = '0;
    b         = '0;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_y", 64'(y), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef GLU_STATS_EN
    chk("reset_txn_count", 64'(txn_count), 64'd0);
`endif
    rst = 1'b0;
    tick();

    // op sweep, one result per cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 8'hA5;
    b         = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      op = op_e'(i[2:0]);
      tick();
      chk($sformatf("sweep_valid_op%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("sweep_y_op%0d", i), 64'(y), 64'(sweep_exp[i]));
    end

    // NOT ignores b
    op = OP_NOT;
    a  = 8'h00;
    b  = 8'($urandom);
    tick();
    chk("not_a00", 64'(y), 64'hFF);
    a = 8'hFF;
    b = 8'($urandom);
    tick();
    chk("not_aFF", 64'(y), 64'h00);
    in_valid = 1'b0;
    tick();
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // backpressure: output stage + skid hold two, third waits
    op        = OP_BUF;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h11;
    tick();
    chk("bp1_y", 64'(y), 64'h11);
    chk("bp1_in_ready", 64'(in_ready), 64'd1);
    a = 8'h22;
    tick();
    chk("bp2_y_stable", 64'(y), 64'h11);
    chk("bp2_in_ready", 64'(in_ready), 64'd0);
    a = 8'h33;
    tick();
    tick();
    chk("bp3_y_stable", 64'(y), 64'h11);
    chk("bp3_in_ready", 64'(in_ready), 64'd0);
    chk("bp3_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_y22", 64'(y), 64'h22);
    chk("bp_rel_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_rel_y33", 64'(y), 64'h33);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // full throughput
    op       = OP_XOR;
    b        = 8'h5A;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = 8'(i);
      tick();
      if (out_valid) results++;
      chk($sformatf("thru_y_%0d", i), 64'(y), 64'(8'(i) ^ 8'h5A));
    end
    chk("thru_count", 64'(results), 64'd100);
    in_valid = 1'b0;
    tick();
    chk("thru_drained", 64'(out_valid), 64'd0);

    // async reset with output stage and skid both full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h44;
    tick();
    a = 8'h55;
    tick();
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_y", 64'(y), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("post_rst_no_skid", 64'(out_valid), 64'd0);

`ifdef GLU_STATS_EN
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk("stats_reset", 64'(txn_count), 64'd0);
    op        = OP_BUF;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("stats_stalled", 64'(txn_count), 64'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 8'(i + 2);
      tick();
    end
    chk("stats_16_wrap", 64'(txn_count), 64'd0);
    in_valid = 1'b0;
    tick();
    chk("stats_17", 64'(txn_count), 64'd1);
    tick();
    chk("stats_idle", 64'(txn_count), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
